// File: rtl/reset_sequencer_if.sv
// Handshake bundle for reset_sequencer: control inputs, per-channel acks and
// the sequenced active-low reset outputs with status flags.
interface reset_sequencer_if #(
    parameter int N_CH = 4
) ();
    logic            en;
    logic            sw_rst_req;
    logic [N_CH-1:0] ch_ack;
    logic [N_CH-1:0] rst_n_out;
    logic            seq_busy;
    logic            seq_done;
    logic            ack_timeout_err;

    modport master (
        output en, sw_rst_req, ch_ack,
        input  rst_n_out, seq_busy, seq_done, ack_timeout_err
    );

    modport slave (
        input  en, sw_rst_req, ch_ack,
        output rst_n_out, seq_busy, seq_done, ack_timeout_err
    );
endinterface

// File: rtl/reset_sequencer.sv
// Holds N_CH active-low resets low for HOLD_CYC en-ticks, then releases them in index
// order with a stagger. Optional per-channel ack wait with timeout under RSTSEQ_ACK_EN.
module reset_sequencer #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.slave  bus
);
    localparam int MAX_HS  = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
    localparam int MAX_CYC = (MAX_HS > ACK_TIMEOUT) ? MAX_HS : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        RELEASE  = 3'd1,
        STAGGER  = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] ch_idx, ch_idx_nx;
    logic [N_CH-1:0]  rst_n_q, rst_n_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic             err_q, err_nx;
    logic             last_ch;

    assign last_ch = (ch_idx == IDX_W'(N_CH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HOLD;
            cnt     <= '0;
            ch_idx  <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ch_idx  <= ch_idx_nx;
            rst_n_q <= rst_n_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        ch_idx_nx = ch_idx;
        rst_n_nx  = rst_n_q;
        busy_nx   = busy_q;
        done_nx   = done_q;
        err_nx    = err_q;
        // A software request behaves exactly like rst but goes through the normal register path
        if (bus.sw_rst_req) begin
            state_nx  = HOLD;
            cnt_nx    = '0;
            ch_idx_nx = '0;
            rst_n_nx  = '0;
            busy_nx   = 1'b1;
            done_nx   = 1'b0;
            err_nx    = 1'b0;
        end else if (bus.en) begin
            case (state)
                HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                        state_nx = RELEASE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    rst_n_nx[ch_idx] = 1'b1;
`ifdef RSTSEQ_ACK_EN
                    state_nx = WAIT_ACK;
                    cnt_nx   = '0;
`else
                    if (last_ch) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = STAGGER;
                        cnt_nx   = '0;
                    end
`endif
                end
                STAGGER: begin
                    if (cnt == CNT_W'(STAGGER_CYC - 1)) begin
                        state_nx  = RELEASE;
                        cnt_nx    = '0;
                        ch_idx_nx = ch_idx + IDX_W'(1);
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
`ifdef RSTSEQ_ACK_EN
                WAIT_ACK: begin
                    // A timeout is flagged but otherwise treated as if the ack had arrived
                    if (bus.ch_ack[ch_idx] || (cnt == CNT_W'(ACK_TIMEOUT - 1))) begin
                        if (!bus.ch_ack[ch_idx]) begin
                            err_nx = 1'b1;
                        end
                        cnt_nx = '0;
                        if (last_ch) begin
                            state_nx = DONE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = STAGGER;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
`endif
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    ch_idx_nx = '0;
                end
            endcase
        end
    end

`ifndef RSTSEQ_ACK_EN
    logic unused_ack;
    assign unused_ack = ^bus.ch_ack;
`endif

    assign bus.rst_n_out       = rst_n_q;
    assign bus.seq_busy        = busy_q;
    assign bus.seq_done        = done_q;
    assign bus.ack_timeout_err = err_q;
endmodule
